// File: rtl/accumulate_pkg.sv
// accumulate_pkg: shared definitions for the accumulate stage.
//   state_t   - FSM state encoding (ACCUM collects products, RESULT presents the sum)
//   acc_width - accumulator width that holds ARGN signed ARGW-bit products without overflow
package accumulate_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    function automatic int acc_width(input int argw, input int argn);
        return argw + $clog2(argn);
    endfunction

endpackage

// File: rtl/saturate.sv
// saturate: purely combinational signed clamp from IW bits to OW bits.
//   din  [IW-1:0] - signed input value
//   dout [OW-1:0] - din clamped to [-2^(OW-1), 2^(OW-1)-1]
// When OW >= IW the value always fits and is simply sign-extended.
module saturate #(
    parameter int IW = 35,
    parameter int OW = 32
) (
    input  logic [IW-1:0] din,
    output logic [OW-1:0] dout
);

    generate
        if (OW >= IW) begin : g_extend
            assign dout = OW'($signed(din));
        end else begin : g_clamp
            // Bits above the output sign bit must all match the input sign,
            // otherwise the value lies outside the output range.
            logic [IW-OW:0] upper;
            assign upper = din[IW-1:OW-1];

            always_comb begin
                dout = din[OW-1:0];
                if (upper != '0 && upper != '1) begin
                    dout = din[IW-1] ? {1'b1, {(OW-1){1'b0}}}
                                     : {1'b0, {(OW-1){1'b1}}};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/accumulate.sv
// accumulate: sums groups of ARGN signed products and emits one signed sum
// per group on a valid/ready result channel.
//   clk, rst              - clock, asynchronous active-high reset
//   arg_valid/arg_ready   - product channel handshake
//   arg_data [ARGW-1:0]   - signed product
//   res_valid/res_ready   - result channel handshake
//   res_data [RESW-1:0]   - signed group sum
// Configuration macro ACCUMULATE_SATURATE_EN: when defined, the sum is
// clamped to the signed RESW range; otherwise it wraps (low RESW bits).
module accumulate
    import accumulate_pkg::*;
#(
    parameter int ARGW = 32,
    parameter int ARGN = 8,
    parameter int RESW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arg_valid,
    output logic            arg_ready,
    input  logic [ARGW-1:0] arg_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [RESW-1:0] res_data
);

    localparam int ACCW = acc_width(ARGW, ARGN);
    localparam int CNTW = $clog2(ARGN);

    state_t          state;
    state_t          state_next;
    logic [ACCW-1:0] acc;
    logic [CNTW-1:0] cnt;
    logic [ACCW-1:0] arg_ext;
    logic [ACCW-1:0] sum;
    logic [RESW-1:0] conv;
    logic            take;
    logic            last;

    assign take    = arg_valid && (state == ACCUM);
    assign last    = (cnt == CNTW'(ARGN - 1));
    assign arg_ext = {{(ACCW-ARGW){arg_data[ARGW-1]}}, arg_data};
    assign sum     = acc + arg_ext;

`ifdef ACCUMULATE_SATURATE_EN
    saturate #(
        .IW(ACCW),
        .OW(RESW)
    ) u_saturate (
        .din (sum),
        .dout(conv)
    );
`else
    generate
        if (RESW >= ACCW) begin : g_wide
            assign conv = RESW'($signed(sum));
        end else begin : g_wrap
            assign conv = sum[RESW-1:0];
        end
    endgenerate
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (take && last) state_next = RESULT;
            RESULT:  if (res_ready)    state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        arg_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            ACCUM:   arg_ready = 1'b1;
            RESULT:  res_valid = 1'b1;
            default: arg_ready = 1'b1;
        endcase
    end

    // Accumulator, element counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            res_data <= '0;
        end else if (take) begin
            if (last) begin
                acc      <= '0;
                cnt      <= '0;
                res_data <= conv;
            end else begin
                acc <= sum;
                cnt <= cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_accumulate.sv
module tb_accumulate;

    localparam int ARGW = 32;
    localparam int ARGN = 4;
    localparam int RESW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            arg_valid = 1'b0;
    logic            arg_ready;
    logic [ARGW-1:0] arg_data = '0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [RESW-1:0] res_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    accumulate #(
        .ARGW(ARGW),
        .ARGN(ARGN),
        .RESW(RESW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arg_valid(arg_valid),
        .arg_ready(arg_ready),
        .arg_data (arg_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data)
    );

    // Reference: exact integer sum of the group, then the configured conversion.
    function automatic logic [31:0] model(input logic [31:0] v [ARGN]);
        longint s = 0;
        longint lo = -(64'sd1 <<< 31);
        longint hi = (64'sd1 <<< 31) - 1;
        for (int i = 0; i < ARGN; i++) s += longint'($signed(v[i]));
`ifdef ACCUMULATE_SATURATE_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`endif
        return s[31:0];
    endfunction

    // Drives ARGN products back-to-back starting at the next falling edge;
    // returns at the falling edge after the last handshake.
    task automatic push_group(input logic [31:0] v [ARGN]);
        for (int i = 0; i < ARGN; i++) begin
            @(negedge clk);
            arg_valid = 1'b1;
            arg_data  = v[i];
        end
        @(negedge clk);
        arg_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (arg_ready !== 1'b1) $display("FAIL reset_arg_ready got=%b exp=1", arg_ready); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got=%b exp=0", res_valid); else passed++;
        total++; if (res_data !== 32'h0) $display("FAIL reset_res_data got=%h exp=0", res_data); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        res_ready = 1'b1;
        for (int i = 0; i < ARGN; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++; if (res_valid !== 1'b0) $display("FAIL basic_early_valid i=%0d got=%b exp=0", i, res_valid); else passed++;
            end
            arg_valid = 1'b1;
            arg_data  = 32'(i + 1);
        end
        @(negedge clk);
        arg_valid = 1'b0;
        total++; if (res_valid !== 1'b1) $display("FAIL basic_res_valid got=%b exp=1", res_valid); else passed++;
        total++; if (arg_ready !== 1'b0) $display("FAIL basic_arg_ready got=%b exp=0", arg_ready); else passed++;
        total++; if (res_data !== 32'd10) $display("FAIL basic_sum got=%h exp=%h", res_data, 32'd10); else passed++;
        @(negedge clk);
        total++; if (res_valid !== 1'b0) $display("FAIL basic_valid_drop got=%b exp=0", res_valid); else passed++;
        total++; if (arg_ready !== 1'b1) $display("FAIL basic_ready_back got=%b exp=1", arg_ready); else passed++;
    endtask

    task automatic test_signed;
        logic [31:0] v [ARGN];
        v = '{32'hFFFFFFFB, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};
        res_ready = 1'b1;
        push_group(v);
        total++; if (res_data !== model(v)) $display("FAIL signed_sum got=%h exp=%h", res_data, model(v)); else passed++;
        total++; if (res_data !== 32'hFFFFFFFC) $display("FAIL signed_sum_const got=%h exp=fffffffc", res_data); else passed++;
    endtask

    task automatic test_overflow;
        logic [31:0] v [ARGN];
        logic [31:0] exp_pos;
        logic [31:0] exp_neg;
`ifdef ACCUMULATE_SATURATE_EN
        exp_pos = 32'h7FFFFFFF;
        exp_neg = 32'h80000000;
`else
        exp_pos = 32'hFFFFFFFC;
        exp_neg = 32'h00000000;
`endif
        res_ready = 1'b1;
        v = '{default: 32'h7FFFFFFF};
        @(negedge clk);
        push_group(v);
        total++; if (res_data !== exp_pos) $display("FAIL overflow_pos got=%h exp=%h", res_data, exp_pos); else passed++;
        v = '{default: 32'h80000000};
        @(negedge clk);
        push_group(v);
        total++; if (res_data !== exp_neg) $display("FAIL overflow_neg got=%h exp=%h", res_data, exp_neg); else passed++;
    endtask

    task automatic test_backpressure;
        logic [31:0] v [ARGN];
        logic [31:0] exp_v;
        int bad = 0;
        for (int i = 0; i < ARGN; i++) v[i] = $urandom;
        exp_v = model(v);
        @(negedge clk);
        res_ready = 1'b0;
        push_group(v);
        // Junk products offered while the result is held must be ignored.
        arg_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            arg_data = $urandom;
            if (res_valid !== 1'b1 || arg_ready !== 1'b0 || res_data !== exp_v) bad++;
            @(negedge clk);
        end
        arg_valid = 1'b0;
        total++; if (bad != 0) $display("FAIL backpressure_hold bad_cycles=%0d exp=0", bad); else passed++;
        total++; if (res_data !== exp_v) $display("FAIL backpressure_data got=%h exp=%h", res_data, exp_v); else passed++;
        res_ready = 1'b1;
        @(negedge clk);
        total++; if (res_valid !== 1'b0) $display("FAIL backpressure_one_transfer got=%b exp=0", res_valid); else passed++;
        // Next group must not contain any of the junk products.
        v = '{32'd7, 32'd8, 32'd9, 32'd10};
        push_group(v);
        total++; if (res_data !== 32'd34) $display("FAIL backpressure_next got=%h exp=%h", res_data, 32'd34); else passed++;
    endtask

    task automatic test_reset_mid_group;
        logic [31:0] v [ARGN];
        @(negedge clk);
        res_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            arg_valid = 1'b1;
            arg_data  = 32'h1234 + 32'(i);
        end
        @(negedge clk);
        arg_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (res_data !== 32'h0) $display("FAIL midrst_res_data got=%h exp=0", res_data); else passed++;
        total++; if (arg_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL midrst_handshake got=%b%b exp=10", arg_ready, res_valid); else passed++;
        @(negedge clk);
        rst = 1'b0;
        v = '{default: 32'd1};
        push_group(v);
        total++; if (res_data !== 32'd4) $display("FAIL midrst_clean_sum got=%h exp=4", res_data); else passed++;
    endtask

    task automatic test_gappy;
        logic [31:0] vals [8*ARGN];
        logic [31:0] grp [ARGN];
        logic [31:0] exp_q [$];
        int got = 0;
        int sent = 0;
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < ARGN; i++) begin
                vals[g*ARGN+i] = $urandom;
                grp[i] = vals[g*ARGN+i];
            end
            exp_q.push_back(model(grp));
        end
        @(negedge clk);
        fork
            begin : driver
                int cyc = 0;
                while (sent < 8*ARGN && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                    arg_valid = ($urandom_range(0, 2) != 0);
                    arg_data  = arg_valid ? vals[sent] : $urandom;
                    // arg_ready only changes on a rising edge, so it is the value seen by the next edge
                    if (arg_valid && arg_ready) sent++;
                end
                @(negedge clk);
                arg_valid = 1'b0;
            end
            begin : receiver
                int cyc = 0;
                while (got < 8 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    res_ready = $urandom_range(0, 1) != 0;
                    if (res_valid && res_ready) begin
                        total++;
                        if (res_data !== exp_q[got]) $display("FAIL gappy_group%0d got=%h exp=%h", got, res_data, exp_q[got]);
                        else passed++;
                        got++;
                    end
                end
            end
        join
        res_ready = 1'b1;
        total++; if (got != 8) $display("FAIL gappy_groups_received got=%0d exp=8", got); else passed++;
        total++; if (sent != 8*ARGN) $display("FAIL gappy_products_sent got=%0d exp=%0d", sent, 8*ARGN); else passed++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signed;
        test_overflow;
        test_backpressure;
        test_reset_mid_group;
        test_gappy;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/accumulate.md
# accumulate

Downstream stage of `multiply`: consumes the stream of signed products on a valid/ready argument channel, sums a fixed-length group of `ARGN` products, and emits one signed sum per group on a valid/ready result channel. Together with `multiply`, it forms the dot-product datapath of a neuron. Each group produces one result, after which the accumulator clears for the next group.

## Interface
- `ARGW`, 32: product (input) width, signed; matches `multiply` result width.
- `ARGN`, 8: products per group; legal range 2..256.
- `RESW`, 32: result width, signed.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `arg_valid` input 1: product presented.
- `arg_ready` output 1: block accepts product this cycle.
- `arg_data` input ARGW: signed product.
- `res_valid` output 1: group sum presented.
- `res_ready` input 1: downstream accepts sum.
- `res_data` output RESW: signed group sum.

## Operation
- Internal accumulator `acc` is `ACCW = ARGW + $clog2(ARGN)` bits signed; it never overflows.
- Each `arg_data` is sign-extended to `ACCW` before adding.
- Element counter `cnt` is `$clog2(ARGN)` bits, counting 0..ARGN-1.
- State machine has two states:
  - ACCUM: `arg_ready`=1, `res_valid`=0. On `arg_valid && arg_ready`: `acc <= acc + arg`, `cnt <= cnt + 1`. When `cnt == ARGN-1`, the accept moves the block to RESULT: `res_data` is registered from `acc + arg` through the output conversion, and `acc` and `cnt` clear to 0.
  - RESULT: `arg_ready`=0, `res_valid`=1, and `res_data` is held stable. On `res_ready`, move to ACCUM.
- `arg_data` is ignored whenever `arg_valid` is 0 or the block is in RESULT.
- The output conversion from `ACCW` to `RESW` is set by configuration (see below).
- An asynchronous reset at any point aborts the partial group. No partial sum is ever emitted.

## Timing
- Reset values: state ACCUM, `acc`=0, `cnt`=0, `arg_ready`=1, `res_valid`=0, `res_data`=0.
- `arg_ready` and `res_valid` are decoded from registered state only. There is no combinational path from `arg_valid` or `res_ready`.
- Latency: `res_valid` rises on the cycle after the ARGN-th product handshake.
- Throughput:
  - one product per cycle while in ACCUM;
  - at least one cycle with `arg_ready`=0 per group (the RESULT cycle);
  - best case is ARGN+1 cycles per group.
- `res_valid`, once high, stays high with `res_data` unchanged until `res_ready` is sampled high.
- When `res_ready` is already high on entry to RESULT, RESULT lasts exactly one cycle. `arg_ready` returns to 1 on the following cycle.
- The handshake rules match `multiply`: a transfer occurs on a rising edge when valid and ready are both 1.

## Configuration
- Macro: `ACCUMULATE_SATURATE_EN`.
- Defined: `res_data` is `acc` clamped to the signed `RESW` range, i.e. [-2^(RESW-1), 2^(RESW-1)-1].
- Undefined: `res_data` is `acc[RESW-1:0]`, i.e. two's-complement wrap with no clamp logic.

## Structure
- Shared package `accumulate_pkg` holds:
  - the state enum (`ACCUM`, `RESULT`);
  - a function computing `ACCW` from `ARGW` and `ARGN`.
- Sub-module `saturate`: purely combinational signed clamp from `ACCW` to `RESW`. It is instantiated only under `ACCUMULATE_SATURATE_EN`.
- The FSM, counter and accumulator live in `accumulate`.

## Test plan
All scenarios use ARGN=4, ARGW=RESW=32, and the same clock/reset/master/slave bench harness used for `multiply`.
- Basic sum: inputs 1, 2, 3, 4 back-to-back with `res_ready`=1 -> `res_data`=10. `res_valid` is high exactly the cycle after the 4th handshake; `arg_ready` is 0 for exactly that one cycle.
- Signed sum: inputs -5, 3, -1, -1 -> `res_data`=0xFFFFFFFC (-4).
- Overflow: 4× 0x7FFFFFFF -> with `ACCUMULATE_SATURATE_EN`, 0x7FFFFFFF; without it, 0xFFFFFFFC. Likewise 4× 0x80000000 -> saturated 0x80000000; wrapped 0x00000000.
- Backpressure: complete a group with `res_ready`=0 for 10 cycles -> `res_valid` stays 1, `res_data` stays stable, and `arg_ready` stays 0 throughout. Raising `res_ready` gives exactly one transfer.
- Gappy input: random `arg_valid` gaps across 8 groups of random values -> each result equals the model sum. Run with forked driver/receiver, including concurrent res_ready toggling.
- Reset mid-group:
  - After 2 products, assert `rst` asynchronously -> outputs return to their reset values immediately.
  - Then inputs 1, 1, 1, 1 -> `res_data`=4, with no residue from the aborted group.
